insn_encoder: RTL

RV32I instruction encoder with an output buffer: the inverse of the control-unit decoder. It accepts decoded fields (format class, funct3, alt bit, register indices, immediate) over a valid/ready handshake and packs them into 32-bit RV32I instruction words. It queues the words in a 2-entry FIFO and emits each one tagged with a running word address. It sits between the lab's test/boot sequencer and the instruction-memory write port, and is used to build programs in-system for the single-cycle core.

---
 rtl/insn_encoder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/insn_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit instruction words
// and queues them, address-tagged, in a 2-entry FIFO for the imem write port.
module insn_encoder #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        fmt_i,
    input  logic [2:0]        funct3_i,
    input  logic              alt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [31:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic [15:0]       count_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [31:0]       word;
    logic              illegal;
    logic [1:0]        occ;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [31:0]       mem_instr [0:1];
    logic [ADDR_W-1:0] mem_addr  [0:1];
    logic [ADDR_W-1:0] next_addr;
    logic [15:0]       count;
    logic              err;
    logic              accept;
    logic              push;
    logic              pop;

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fmt_i)
            4'd0: begin
                word    = {1'b0, alt_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
                illegal = alt_i && (funct3_i != 3'b000) && (funct3_i != 3'b101);
            end
            4'd1: begin
                if (funct3_i == 3'b001 || funct3_i == 3'b101)
                    word = {1'b0, alt_i, 5'b0, imm_i[4:0], rs1_i, funct3_i, rd_i, OP_I};
                else
                    word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
                illegal = (funct3_i == 3'b001) && alt_i;
            end
            4'd2: begin
                word    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
                illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
            end
            4'd3: begin
                word    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
                illegal = funct3_i > 3'b010;
            end
            4'd4: begin
                word    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], OP_BRANCH};
                illegal = (funct3_i == 3'b010) || (funct3_i == 3'b011) || imm_i[0];
            end
            4'd5: word = {imm_i[31:12], rd_i, OP_LUI};
            4'd6: word = {imm_i[31:12], rd_i, OP_AUIPC};
            4'd7: begin
                word    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
                illegal = imm_i[0];
            end
            4'd8: begin
                word    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_JALR};
                illegal = funct3_i != 3'b000;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Ready comes from registered occupancy only; a same-cycle pop does not free a slot.
    assign req_ready_o = occ != 2'd2;
    assign out_valid_o = occ != 2'd0;
    assign accept      = req_valid_i && req_ready_o;
    assign push        = accept && !illegal;
    assign pop         = out_valid_o && out_ready_i;

    assign instr_o = mem_instr[rd_ptr];
    assign addr_o  = mem_addr[rd_ptr];
    assign err_o   = err;
    assign count_o = count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ          <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            mem_instr[0] <= '0;
            mem_instr[1] <= '0;
            mem_addr[0]  <= BASE_ADDR;
            mem_addr[1]  <= BASE_ADDR;
            next_addr    <= BASE_ADDR;
            count        <= '0;
            err          <= 1'b0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= word;
                mem_addr[wr_ptr]  <= next_addr;
                wr_ptr            <= ~wr_ptr;
                next_addr         <= next_addr + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                count  <= count + 16'd1;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (accept && illegal)
                err <= 1'b1;
        end
    end

endmodule
